// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single 256-bit Data_Memory port (icache = port 0, dcache = port 1).
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build is fixed priority with port 1 first.
module mem_arbiter #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              dbg_state_o,
  output logic              dbg_owner_o
);

  // Handshake: a requester raises pN_enable_i with stable write/addr/data and holds them until
  // pN_ack_o; the memory side sees mem_enable_o held with constant mem_* until its mem_ack_i pulse.

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                mem_enable_d;
  logic                mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_data_d;
  logic                any_req;
  logic                grant_p1;
  logic                ack_hit;

  assign any_req = p0_enable_i | p1_enable_i;

`ifdef MEM_ARB_RR_EN
  // Contention goes to the port that was not served last.
  assign grant_p1 = p1_enable_i & (~p0_enable_i | ~last_q);
`else
  assign grant_p1 = p1_enable_i;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      mem_enable_o <= mem_enable_d;
      mem_write_o  <= mem_write_d;
      mem_addr_o   <= mem_addr_d;
      mem_data_o   <= mem_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    mem_enable_d = mem_enable_o;
    mem_write_d  = mem_write_o;
    mem_addr_d   = mem_addr_o;
    mem_data_d   = mem_data_o;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = BUSY;
          owner_d      = grant_p1;
          mem_enable_d = 1'b1;
          mem_write_d  = grant_p1 ? p1_write_i : p0_write_i;
          mem_addr_d   = grant_p1 ? p1_addr_i  : p0_addr_i;
          mem_data_d   = grant_p1 ? p1_data_i  : p0_data_i;
        end
      end
      BUSY: begin
        // The owner's enable is not consulted here: a dropped request still completes.
        if (mem_ack_i) begin
          state_d      = IDLE;
          mem_enable_d = 1'b0;
          last_d       = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack_hit   = mem_ack_i & (state_q == BUSY);
  assign p0_ack_o  = ack_hit & ~owner_q;
  assign p1_ack_o  = ack_hit & owner_q;
  assign p0_data_o = ((state_q == BUSY) && !owner_q) ? mem_data_i : '0;
  assign p1_data_o = ((state_q == BUSY) && owner_q)  ? mem_data_i : '0;

  assign dbg_state_o = state_q;
  assign dbg_owner_o = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected grants are queued when requests are driven and
// popped when mem_enable_o rises; acks are checked on the cycle mem_ack_i is driven.
module tb_mem_arbiter;
  localparam int DATA_W = 256;
  localparam int ADDR_W = 32;
  localparam int REC_W  = 2 + ADDR_W + DATA_W;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
  logic [ADDR_W-1:0] p0_addr_i, p1_addr_i;
  logic [DATA_W-1:0] p0_data_i, p1_data_i, p0_data_o, p1_data_o;
  logic              p0_ack_o, p1_ack_o;
  logic              mem_enable_o, mem_write_o, mem_ack_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o, mem_data_i;
  logic              dbg_state_o, dbg_owner_o;

  int checks = 0;
  int errors = 0;
  logic [REC_W-1:0] exp_q[$];

  mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
    .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
    .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .dbg_state_o(dbg_state_o), .dbg_owner_o(dbg_owner_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] rand256();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [REC_W-1:0] mk_rec(input logic port, input logic wr,
                                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    return {port, wr, a, d};
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b0;
    p0_enable_i = 0; p0_write_i = 0; p0_addr_i = '0; p0_data_i = '0;
    p1_enable_i = 0; p1_write_i = 0; p1_addr_i = '0; p1_data_i = '0;
    mem_ack_i = 0; mem_data_i = rand256();
    step(); step();
    @(negedge clk_i);
    chk("rst_en", mem_enable_o, 0);
    chk("rst_wr", mem_write_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", mem_data_o, 0);
    chk("rst_state", dbg_state_o, 0);
    chk("rst_owner", dbg_owner_o, 0);
    step();
    rst_i = 1'b1;
  endtask

  // Assumes the sampling point of a cycle where mem_enable_o is expected high.
  task automatic check_grant(input string tag);
    logic [REC_W-1:0] r;
    chk({tag, "_en"}, mem_enable_o, 1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=grant expected=none", tag);
    end else begin
      r = exp_q.pop_front();
      chk({tag, "_owner"}, dbg_owner_o, r[REC_W-1]);
      chk({tag, "_wr"}, mem_write_o, r[REC_W-2]);
      chk({tag, "_addr"}, mem_addr_o, r[DATA_W +: ADDR_W]);
      chk({tag, "_data"}, mem_data_o, r[DATA_W-1:0]);
    end
  endtask

  task automatic wait_grant(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      @(negedge clk_i);
      seen = mem_enable_o;
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no_grant expected=grant", tag);
    end else check_grant(tag);
  endtask

  // Drives a one-cycle mem_ack_i in the current cycle, then clears the enables in drop.
  task automatic do_ack(input string tag, input logic port, input logic [DATA_W-1:0] d,
                        input logic [1:0] drop);
    mem_ack_i = 1'b1;
    mem_data_i = d;
    @(negedge clk_i);
    chk({tag, "_en_hold"}, mem_enable_o, 1);
    if (port) begin
      chk({tag, "_p1ack"}, p1_ack_o, 1);
      chk({tag, "_p1data"}, p1_data_o, d);
      chk({tag, "_p0ack"}, p0_ack_o, 0);
      chk({tag, "_p0data"}, p0_data_o, 0);
    end else begin
      chk({tag, "_p0ack"}, p0_ack_o, 1);
      chk({tag, "_p0data"}, p0_data_o, d);
      chk({tag, "_p1ack"}, p1_ack_o, 0);
      chk({tag, "_p1data"}, p1_data_o, 0);
    end
    step();
    mem_ack_i = 1'b0;
    mem_data_i = rand256();
    if (drop[0]) p0_enable_i = 1'b0;
    if (drop[1]) p1_enable_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_en_off"}, mem_enable_o, 0);
    chk({tag, "_ack_off"}, {p1_ack_o, p0_ack_o}, 0);
    chk({tag, "_idle"}, dbg_state_o, 0);
  endtask

  initial begin
    logic port;
    apply_reset();

    // 1: p0 read 0x40, ack in cycle 4
    p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h40; p0_data_i = '0;
    exp_q.push_back(mk_rec(0, 0, 32'h40, '0));
    @(negedge clk_i);
    chk("t1_c0_en", mem_enable_o, 0);
    step();
    @(negedge clk_i);
    check_grant("t1_c1");
    for (int c = 2; c <= 3; c++) begin
      step();
      @(negedge clk_i);
      chk("t1_busy_en", mem_enable_o, 1);
      chk("t1_busy_addr", mem_addr_o, 32'h40);
      chk("t1_busy_wr", mem_write_o, 0);
    end
    step();
    do_ack("t1_ack", 0, {8{32'hA5A5A5A5}}, 2'b01);

    // 2: simultaneous requests from reset, p1 first in both modes
    apply_reset();
    p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h100; p0_data_i = rand256();
    p1_enable_i = 1; p1_write_i = 1; p1_addr_i = 32'h200; p1_data_i = 256'hDEAD;
    exp_q.push_back(mk_rec(1, 1, 32'h200, 256'hDEAD));
    exp_q.push_back(mk_rec(0, 0, 32'h100, p0_data_i));
    wait_grant("t2_p1");
    step();
    do_ack("t2_ack1", 1, rand256(), 2'b10);
    step();
    @(negedge clk_i);
    check_grant("t2_p0");
    step();
    do_ack("t2_ack0", 0, rand256(), 2'b01);

    // 3: both ports keep requesting for 6 transactions
    p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h300; p0_data_i = rand256();
    p1_enable_i = 1; p1_write_i = 1; p1_addr_i = 32'h400; p1_data_i = 256'hBEEF;
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_RR_EN
      port = (i % 2 == 0);
`else
      port = 1'b1;
`endif
      if (port) exp_q.push_back(mk_rec(1, 1, 32'h400, 256'hBEEF));
      else      exp_q.push_back(mk_rec(0, 0, 32'h300, p0_data_i));
      wait_grant("t3_grant");
      step();
      do_ack("t3_ack", port, rand256(), (i == 5) ? 2'b11 : 2'b00);
    end

    // 4: stray mem_ack_i in IDLE
    step();
    mem_ack_i = 1; mem_data_i = rand256();
    @(negedge clk_i);
    chk("t4_acks", {p1_ack_o, p0_ack_o}, 0);
    chk("t4_p0data", p0_data_o, 0);
    chk("t4_en", mem_enable_o, 0);
    chk("t4_state", dbg_state_o, 0);
    step();
    mem_ack_i = 0;
    @(negedge clk_i);
    chk("t4_en_after", mem_enable_o, 0);
    p0_enable_i = 1; p0_write_i = 1; p0_addr_i = 32'h500; p0_data_i = rand256();
    exp_q.push_back(mk_rec(0, 1, 32'h500, p0_data_i));
    wait_grant("t4_grant");
    step();
    do_ack("t4_ack", 0, rand256(), 2'b01);

    // 5: reset mid-BUSY drops the transaction
    step();
    p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h600; p0_data_i = rand256();
    exp_q.push_back(mk_rec(0, 0, 32'h600, p0_data_i));
    wait_grant("t5_grant");
    step();
    #2;
    rst_i = 0;
    mem_ack_i = 1; mem_data_i = rand256();
    #1;
    chk("t5_rst_en", mem_enable_o, 0);
    chk("t5_rst_acks", {p1_ack_o, p0_ack_o}, 0);
    chk("t5_rst_state", dbg_state_o, 0);
    step();
    mem_ack_i = 0;
    rst_i = 1;
    exp_q.push_back(mk_rec(0, 0, 32'h600, p0_data_i));
    @(negedge clk_i);
    chk("t5_release_en", mem_enable_o, 0);
    step();
    @(negedge clk_i);
    check_grant("t5_regrant");
    step();
    do_ack("t5_ack", 0, rand256(), 2'b01);

    // 6: p1 arrives mid-BUSY of p0 and waits
    step();
    p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h700; p0_data_i = rand256();
    exp_q.push_back(mk_rec(0, 0, 32'h700, p0_data_i));
    wait_grant("t6_p0");
    step();
    p1_enable_i = 1; p1_write_i = 0; p1_addr_i = 32'h800; p1_data_i = rand256();
    exp_q.push_back(mk_rec(1, 0, 32'h800, p1_data_i));
    @(negedge clk_i);
    chk("t6_hold_addr", mem_addr_o, 32'h700);
    chk("t6_hold_owner", dbg_owner_o, 0);
    step();
    @(negedge clk_i);
    chk("t6_hold_addr2", mem_addr_o, 32'h700);
    step();
    do_ack("t6_ack0", 0, rand256(), 2'b01);
    step();
    @(negedge clk_i);
    check_grant("t6_p1");
    step();
    do_ack("t6_ack1", 1, rand256(), 2'b10);

    // 7: owner drops enable mid-BUSY, transaction still completes
    step();
    p1_enable_i = 1; p1_write_i = 1; p1_addr_i = 32'h900; p1_data_i = rand256();
    exp_q.push_back(mk_rec(1, 1, 32'h900, p1_data_i));
    wait_grant("t7_grant");
    step();
    p1_enable_i = 0;
    @(negedge clk_i);
    chk("t7_en_kept", mem_enable_o, 1);
    chk("t7_state", dbg_state_o, 1);
    step();
    do_ack("t7_ack", 1, rand256(), 2'b00);

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
